// File: rtl/controle_pc.sv
// Program-counter sequencing controller: fetch wait, execute, I/O wait and halt.
// Define CONTROLE_PC_CONTADOR_EN to add the numInstr retired-instruction counter port.
module controle_pc #(
  parameter int unsigned LAT_MEM    = 2,
  parameter logic [25:0] PC_INICIAL = 26'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [25:0] pcProx,
  input  logic        ioAck,
  output logic [25:0] pc,
  output logic [1:0]  addOp,
  output logic        ioReq,
  output logic        halt
`ifdef CONTROLE_PC_CONTADOR_EN
  ,
  output logic [31:0] numInstr
`endif
);

  localparam logic [1:0] BUSCA     = 2'd0;
  localparam logic [1:0] EXECUTA   = 2'd1;
  localparam logic [1:0] ESPERA_IO = 2'd2;
  localparam logic [1:0] PARADO    = 2'd3;

  localparam logic [1:0] ADD_HOLD  = 2'b00;
  localparam logic [1:0] ADD_INC   = 2'b01;
  localparam logic [1:0] ADD_COND  = 2'b10;
  localparam logic [1:0] ADD_JUMP  = 2'b11;

  localparam logic [5:0] OP_BEQ  = 6'b010111;
  localparam logic [5:0] OP_BNE  = 6'b011000;
  localparam logic [5:0] OP_BLT  = 6'b011001;
  localparam logic [5:0] OP_BLET = 6'b011010;
  localparam logic [5:0] OP_BGT  = 6'b011011;
  localparam logic [5:0] OP_BGET = 6'b011100;
  localparam logic [5:0] OP_J    = 6'b011101;
  localparam logic [5:0] OP_JAL  = 6'b011110;
  localparam logic [5:0] OP_JR   = 6'b011111;
  localparam logic [5:0] OP_IN   = 6'b100000;
  localparam logic [5:0] OP_OUT  = 6'b100001;
  localparam logic [5:0] OP_HLT  = 6'b111111;

  localparam logic [3:0] CNT_INICIAL = 4'(LAT_MEM - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [25:0] pc_q, pc_d;
  logic        retire;

  // Next state and adder operation; addOp must settle within the cycle for the adder.
  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_INICIAL;
    addOp   = ADD_HOLD;
    case (state_q)
      BUSCA: begin
        if (cnt_q == 4'd0) begin
          state_d = EXECUTA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      EXECUTA: begin
        state_d = BUSCA;
        case (opcode)
          OP_BEQ, OP_BNE, OP_BLT, OP_BLET, OP_BGT, OP_BGET,
          OP_JAL, OP_JR: addOp = ADD_COND;
          OP_J:          addOp = ADD_JUMP;
          OP_IN, OP_OUT: state_d = ESPERA_IO;
          OP_HLT:        state_d = PARADO;
          default:       addOp = ADD_INC;
        endcase
      end
      ESPERA_IO: begin
        if (ioAck) begin
          addOp   = ADD_INC;
          state_d = BUSCA;
        end
      end
      default: state_d = PARADO;
    endcase
  end

  assign retire = (addOp != ADD_HOLD);
  assign pc_d   = retire ? pcProx : pc_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BUSCA;
      cnt_q   <= CNT_INICIAL;
      pc_q    <= PC_INICIAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign pc    = pc_q;
  assign ioReq = (state_q == ESPERA_IO);
  assign halt  = (state_q == PARADO);

`ifdef CONTROLE_PC_CONTADOR_EN
  logic [31:0] numInstr_q;

  // PARADO never retires, so the count freezes there without extra gating.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      numInstr_q <= 32'd0;
    end else if (retire) begin
      numInstr_q <= numInstr_q + 32'd1;
    end
  end

  assign numInstr = numInstr_q;
`endif

endmodule

// File: tb/tb_controle_pc.sv
// Randomized self-checking bench for controle_pc against an instruction-level timing model.
module tb_controle_pc;

  localparam int unsigned LAT   = 2;
  localparam logic [25:0] PCINI = 26'd5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  opcode = 6'd0;
  logic [25:0] pcProx = 26'd0;
  logic        ioAck = 1'b0;
  logic [25:0] pc;
  logic [1:0]  addOp;
  logic        ioReq;
  logic        halt;
`ifdef CONTROLE_PC_CONTADOR_EN
  logic [31:0] numInstr;
`endif

  int numChecks = 0;
  int numFails  = 0;
  logic [25:0] expPc = PCINI;
  logic [31:0] expCount = 32'd0;

  controle_pc #(.LAT_MEM(LAT), .PC_INICIAL(PCINI)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .pcProx(pcProx), .ioAck(ioAck),
    .pc(pc), .addOp(addOp), .ioReq(ioReq), .halt(halt)
`ifdef CONTROLE_PC_CONTADOR_EN
    , .numInstr(numInstr)
`endif
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Adder operation each opcode class should request in its execute cycle.
  function automatic logic [1:0] classAdd(input logic [5:0] op);
    if (op >= 6'b010111 && op <= 6'b011100) return 2'b10;
    if (op == 6'b011110 || op == 6'b011111) return 2'b10;
    if (op == 6'b011101) return 2'b11;
    if (op == 6'b100000 || op == 6'b100001 || op == 6'b111111) return 2'b00;
    return 2'b01;
  endfunction

  // Called at a falling edge: drives one cycle of inputs, checks outputs, waits for the next falling edge.
  task automatic expectCycle(input logic [5:0] op, input logic [25:0] nxt, input logic ack,
                             input logic [1:0] expAdd, input logic expReq, input logic expHalt);
    opcode = op;
    pcProx = nxt;
    ioAck  = ack;
    #1;
    checkOutput("addOp", 32'(addOp), 32'(expAdd));
    checkOutput("pc", 32'(pc), 32'(expPc));
    checkOutput("ioReq", 32'(ioReq), 32'(expReq));
    checkOutput("halt", 32'(halt), 32'(expHalt));
`ifdef CONTROLE_PC_CONTADOR_EN
    checkOutput("numInstr", numInstr, expCount);
`endif
    @(negedge clock);
  endtask

  // One whole instruction: LAT fetch cycles, execute, and for IN/OUT k wait cycles plus the ack cycle.
  task automatic applyStimulus(input logic [5:0] op, input logic [25:0] nxt, input int k);
    logic [1:0] a;
    for (int i = 0; i < int'(LAT); i++)
      expectCycle(6'($urandom), 26'($urandom), 1'($urandom_range(0, 1)), 2'b00, 1'b0, 1'b0);
    a = classAdd(op);
    expectCycle(op, nxt, 1'($urandom_range(0, 1)), a, 1'b0, 1'b0);
    if (a != 2'b00) begin
      expPc = nxt;
      expCount++;
    end else if (op == 6'b100000 || op == 6'b100001) begin
      for (int i = 0; i < k; i++)
        expectCycle(6'($urandom), 26'($urandom), 1'b0, 2'b00, 1'b1, 1'b0);
      expectCycle(6'($urandom), nxt, 1'b1, 2'b01, 1'b1, 1'b0);
      expPc = nxt;
      expCount++;
    end
  endtask

  function automatic logic [5:0] randOp();
    logic [5:0] o;
    case ($urandom_range(0, 4))
      0, 1: begin
        o = 6'($urandom);
        if (o == 6'b111111) o = 6'b000000;
      end
      2: o = 6'(6'b010111 + 6'($urandom_range(0, 5)));
      3: o = 6'(6'b011101 + 6'($urandom_range(0, 2)));
      default: o = 6'(6'b100000 + 6'($urandom_range(0, 1)));
    endcase
    return o;
  endfunction

  task automatic haltPhase(input int cycles);
    applyStimulus(6'b111111, 26'($urandom), 0);
    for (int i = 0; i < cycles; i++)
      expectCycle(6'($urandom), 26'($urandom), 1'($urandom_range(0, 1)), 2'b00, 1'b0, 1'b1);
  endtask

  task automatic asyncReset();
    #2 reset = 1'b0;
    #1;
    expPc    = PCINI;
    expCount = 32'd0;
    checkOutput("rst_pc", 32'(pc), 32'(PCINI));
    checkOutput("rst_halt", 32'(halt), 32'd0);
    checkOutput("rst_ioReq", 32'(ioReq), 32'd0);
    checkOutput("rst_addOp", 32'(addOp), 32'd0);
`ifdef CONTROLE_PC_CONTADOR_EN
    checkOutput("rst_numInstr", numInstr, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    #1;
    checkOutput("rst_pc", 32'(pc), 32'(PCINI));
    checkOutput("rst_addOp", 32'(addOp), 32'd0);
    checkOutput("rst_ioReq", 32'(ioReq), 32'd0);
    checkOutput("rst_halt", 32'(halt), 32'd0);
    #1 reset = 1'b1;

    // Directed walk: 5 -> 6 -> 7, jump to 100, branches, IN at pc 3 with a 4-cycle wait.
    applyStimulus(6'b000000, 26'd6, 0);
    applyStimulus(6'b000001, 26'd7, 0);
    applyStimulus(6'b011101, 26'd100, 0);
    applyStimulus(6'b000010, 26'd20, 0);
    applyStimulus(6'b010111, 26'd40, 0);
    applyStimulus(6'b000011, 26'd20, 0);
    applyStimulus(6'b010111, 26'd21, 0);
    applyStimulus(6'b011110, 26'd3, 0);
    applyStimulus(6'b100000, 26'd4, 4);
    applyStimulus(6'b100001, 26'd5, 0);
    applyStimulus(6'b011111, 26'h3FFFFFF, 0);
    applyStimulus(6'b111110, 26'd0, 0);

    for (int n = 0; n < 60; n++)
      applyStimulus(randOp(), 26'($urandom), int'($urandom_range(0, 5)));

    applyStimulus(6'b000100, 26'd9, 0);
    haltPhase(50);
    asyncReset();

    for (int n = 0; n < 10; n++)
      applyStimulus(6'($urandom_range(0, 22)), 26'($urandom), 0);
    applyStimulus(6'b100001, 26'($urandom), int'($urandom_range(0, 3)));
`ifdef CONTROLE_PC_CONTADOR_EN
    checkOutput("count11", numInstr, 32'd11);
`endif
    haltPhase(10);
`ifdef CONTROLE_PC_CONTADOR_EN
    checkOutput("countHalt", numInstr, 32'd11);
`endif
    asyncReset();
    applyStimulus(6'b000000, 26'd6, 0);
    applyStimulus(6'b100000, 26'd7, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
